// File: rtl/lut3d_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// lut3d_fetch_ctrl_if
// Bundles the pixel handshake, the LUT read port, the interpolator request
// and the result-credit return of the 3D LUT fetch sequencer.
//   slave  : the sequencer side (lut3d_fetch_ctrl)
//   master : the surrounding pipeline / memory / interpolator side
// Signals:
//   pix_valid/pix_ready/pix_data   pixel stream, {B,G,R}
//   lut_rd_en/lut_rd_addr          LUT read strobe and address
//   lut_rd_data                    returned corner {B,G,R}
//   interp_valid, frac_r/g/b       interpolator request and fractions
//   pt_nbr                         8 corners, corner k at [k*3*CD +: 3*CD]
//   res_pop                        downstream result FIFO popped one entry
//   busy                           sequencer not idle
// ---------------------------------------------------------------------------
interface lut3d_fetch_ctrl_if #(
    parameter int CD  = 8,
    parameter int OFW = 8,
    parameter int AW  = 13
);
    logic                pix_valid;
    logic                pix_ready;
    logic [3*CD-1:0]     pix_data;
    logic                lut_rd_en;
    logic [AW-1:0]       lut_rd_addr;
    logic [3*CD-1:0]     lut_rd_data;
    logic                interp_valid;
    logic [OFW-1:0]      frac_r;
    logic [OFW-1:0]      frac_g;
    logic [OFW-1:0]      frac_b;
    logic [8*3*CD-1:0]   pt_nbr;
    logic                res_pop;
    logic                busy;

    modport slave (
        input  pix_valid, pix_data, lut_rd_data, res_pop,
        output pix_ready, lut_rd_en, lut_rd_addr, interp_valid,
               frac_r, frac_g, frac_b, pt_nbr, busy
    );

    modport master (
        output pix_valid, pix_data, lut_rd_data, res_pop,
        input  pix_ready, lut_rd_en, lut_rd_addr, interp_valid,
               frac_r, frac_g, frac_b, pt_nbr, busy
    );
endinterface

// File: rtl/lut3d_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// lut3d_fetch_ctrl
// Sequencer between the pixel stream and the trilinear interpolator of the
// 3D colour LUT. Takes one {B,G,R} pixel, splits every channel into a lattice
// index and a fraction, reads the 8 surrounding lattice corners from a
// single-port LUT memory, collects them, and issues one interpolation
// request, but only while the downstream result FIFO has a free credit.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   bus         lut3d_fetch_ctrl_if.slave (pixel, LUT, interpolator, credits)
// Optional feature (macro LUT3D_CTRL_STATS_EN):
//   stat_pix_cnt   count of interpolation requests issued
//   stat_stall_cnt count of cycles stalled in ISSUE for lack of credit
// ---------------------------------------------------------------------------
module lut3d_fetch_ctrl #(
    parameter int CD      = 8,
    parameter int IW      = 4,
    parameter int OFW     = 8,
    parameter int AW      = 13,
    parameter int MEM_LAT = 2,
    parameter int CREDITS = 8
) (
    input  logic               clk,
    input  logic               rstn,
    lut3d_fetch_ctrl_if.slave  bus
`ifdef LUT3D_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_pix_cnt,
    output logic [31:0]        stat_stall_cnt
`endif
);

    localparam int FW = CD - IW;
    localparam int PW = 3 * CD;
    localparam int CW = $clog2(CREDITS + 1);
    localparam int TW = 4;  // tag = {valid, corner[2:0]}

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic [IW-1:0]       idx_r_q, idx_r_d, idx_g_q, idx_g_d, idx_b_q, idx_b_d;
    logic [OFW-1:0]      frac_r_q, frac_r_d, frac_g_q, frac_g_d, frac_b_q, frac_b_d;
    logic                lut_rd_en_q, lut_rd_en_d;
    logic [AW-1:0]       lut_rd_addr_q, lut_rd_addr_d;
    logic [MEM_LAT*TW-1:0] tag_q, tag_d;
    logic [8*PW-1:0]     pt_nbr_q, pt_nbr_d;
    logic [CW-1:0]       credit_q, credit_d;

    logic [CD-1:0]       pix_r, pix_g, pix_b;
    logic [TW-1:0]       tag_out;
    logic                tag_vld;
    logic [2:0]          tag_k;
    logic                issue;
    logic                pop_ok;

    // Lattice address (b*G + g)*G + r in Horner form; x*G = (x << IW) + x,
    // so only shifts and adders are needed.
    function automatic logic [AW-1:0] corner_addr(
        input logic [IW-1:0] ir,
        input logic [IW-1:0] ig,
        input logic [IW-1:0] ib,
        input logic [2:0]    k
    );
        logic [AW-1:0] r, g, b, acc;
        r   = AW'(ir) + AW'(k[0]);
        g   = AW'(ig) + AW'(k[1]);
        b   = AW'(ib) + AW'(k[2]);
        acc = (b << IW) + b + g;
        acc = (acc << IW) + acc + r;
        return acc;
    endfunction

    assign pix_r   = bus.pix_data[CD-1:0];
    assign pix_g   = bus.pix_data[2*CD-1:CD];
    assign pix_b   = bus.pix_data[3*CD-1:2*CD];

    assign tag_out = tag_q[MEM_LAT*TW-1 -: TW];
    assign tag_vld = tag_out[3];
    assign tag_k   = tag_out[2:0];

    assign issue   = (state_q == ISSUE) && (credit_q != '0);
    // A pop with every credit already home cannot be real; drop it.
    assign pop_ok  = bus.res_pop && (credit_q != CW'(CREDITS));

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        idx_r_d       = idx_r_q;
        idx_g_d       = idx_g_q;
        idx_b_d       = idx_b_q;
        frac_r_d      = frac_r_q;
        frac_g_d      = frac_g_q;
        frac_b_d      = frac_b_q;
        lut_rd_en_d   = 1'b0;
        lut_rd_addr_d = lut_rd_addr_q;
        case (state_q)
            IDLE: begin
                if (bus.pix_valid) begin
                    idx_r_d       = pix_r[CD-1 -: IW];
                    idx_g_d       = pix_g[CD-1 -: IW];
                    idx_b_d       = pix_b[CD-1 -: IW];
                    frac_r_d      = OFW'(pix_r[FW-1:0]) << (OFW - FW);
                    frac_g_d      = OFW'(pix_g[FW-1:0]) << (OFW - FW);
                    frac_b_d      = OFW'(pix_b[FW-1:0]) << (OFW - FW);
                    // Corner 0 read goes out in the first FETCH cycle.
                    k_d           = 3'd0;
                    lut_rd_en_d   = 1'b1;
                    lut_rd_addr_d = corner_addr(pix_r[CD-1 -: IW], pix_g[CD-1 -: IW],
                                                pix_b[CD-1 -: IW], 3'd0);
                    state_d       = FETCH;
                end
            end
            FETCH: begin
                if (k_q == 3'd7) begin
                    state_d = WAIT;
                end else begin
                    k_d           = k_q + 3'd1;
                    lut_rd_en_d   = 1'b1;
                    lut_rd_addr_d = corner_addr(idx_r_q, idx_g_q, idx_b_q, k_q + 3'd1);
                end
            end
            WAIT: begin
                if (tag_vld && (tag_k == 3'd7)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_q != '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipeline shifts {strobe, corner} alongside the memory latency;
    // a tag leaving the far end marks lut_rd_data as belonging to that corner.
    always_comb begin
        tag_d    = (MEM_LAT*TW)'({tag_q, lut_rd_en_q, k_q});
        pt_nbr_d = pt_nbr_q;
        if (tag_vld) begin
            pt_nbr_d[tag_k*PW +: PW] = bus.lut_rd_data;
        end
    end

    always_comb begin
        credit_d = credit_q;
        case ({issue, pop_ok})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            k_q           <= '0;
            idx_r_q       <= '0;
            idx_g_q       <= '0;
            idx_b_q       <= '0;
            frac_r_q      <= '0;
            frac_g_q      <= '0;
            frac_b_q      <= '0;
            lut_rd_en_q   <= 1'b0;
            lut_rd_addr_q <= '0;
            tag_q         <= '0;
            pt_nbr_q      <= '0;
            credit_q      <= CW'(CREDITS);
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            idx_r_q       <= idx_r_d;
            idx_g_q       <= idx_g_d;
            idx_b_q       <= idx_b_d;
            frac_r_q      <= frac_r_d;
            frac_g_q      <= frac_g_d;
            frac_b_q      <= frac_b_d;
            lut_rd_en_q   <= lut_rd_en_d;
            lut_rd_addr_q <= lut_rd_addr_d;
            tag_q         <= tag_d;
            pt_nbr_q      <= pt_nbr_d;
            credit_q      <= credit_d;
        end
    end

    always @(posedge clk) begin
        if (rstn) begin
            assert (!(bus.res_pop && (credit_q == CW'(CREDITS))))
                else $error("lut3d_fetch_ctrl: res_pop with all credits returned");
        end
    end

    assign bus.pix_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.lut_rd_en    = lut_rd_en_q;
    assign bus.lut_rd_addr  = lut_rd_addr_q;
    assign bus.interp_valid = issue;
    assign bus.frac_r       = frac_r_q;
    assign bus.frac_g       = frac_g_q;
    assign bus.frac_b       = frac_b_q;
    assign bus.pt_nbr       = pt_nbr_q;

`ifdef LUT3D_CTRL_STATS_EN
    logic [31:0] stat_pix_cnt_q, stat_pix_cnt_d;
    logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

    always_comb begin
        stat_pix_cnt_d   = stat_pix_cnt_q + (issue ? 32'd1 : 32'd0);
        stat_stall_cnt_d = stat_stall_cnt_q
                         + (((state_q == ISSUE) && (credit_q == '0)) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_pix_cnt_q   <= '0;
            stat_stall_cnt_q <= '0;
        end else begin
            stat_pix_cnt_q   <= stat_pix_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_pix_cnt   = stat_pix_cnt_q;
    assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule

// File: tb/tb_lut3d_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lut3d_fetch_ctrl
// Directed bench for lut3d_fetch_ctrl. A behavioural LUT memory returns the
// read address as data after MEM_LAT cycles, so every captured corner equals
// its lattice address.
// ---------------------------------------------------------------------------
module tb_lut3d_fetch_ctrl;

    localparam int CD      = 8;
    localparam int IW      = 4;
    localparam int OFW     = 8;
    localparam int AW      = 13;
    localparam int MEM_LAT = 2;
    localparam int CREDITS = 8;

    logic clk = 1'b0;
    logic rstn;
    int   test_count = 0;
    int   fail_count = 0;

    lut3d_fetch_ctrl_if #(.CD(CD), .OFW(OFW), .AW(AW)) bus_if ();

`ifdef LUT3D_CTRL_STATS_EN
    logic [31:0] stat_pix;
    logic [31:0] stat_stall;
`endif

    lut3d_fetch_ctrl #(
        .CD(CD), .IW(IW), .OFW(OFW), .AW(AW), .MEM_LAT(MEM_LAT), .CREDITS(CREDITS)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
`ifdef LUT3D_CTRL_STATS_EN
        ,
        .stat_pix_cnt   (stat_pix),
        .stat_stall_cnt (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Two-stage memory model (MEM_LAT = 2): data = address, filler otherwise.
    logic          mem_vld0 = 1'b0, mem_vld1 = 1'b0;
    logic [AW-1:0] mem_addr0 = '0, mem_addr1 = '0;

    always @(posedge clk) begin
        mem_vld1  <= mem_vld0;
        mem_addr1 <= mem_addr0;
        mem_vld0  <= bus_if.lut_rd_en;
        mem_addr0 <= bus_if.lut_rd_addr;
    end

    assign bus_if.lut_rd_data = mem_vld1 ? 24'(mem_addr1) : 24'hA5A5A5;

    task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        test_count++;
        assert (obs === exp)
            else begin
                fail_count++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // Presents one pixel for a single handshake cycle; returns 1ns into cycle 1.
    task automatic applyStimulus(input logic [23:0] pix);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_data  = pix;
        @(posedge clk);
        #1;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = 24'h5A5A5A;
    endtask

    // Full-check pixel: addresses in cycles 1..8, request in cycle 11.
    task automatic runPixel(input string tag, input logic [23:0] pix,
                            input logic [7:0][12:0] addrs,
                            input logic [7:0] fr, input logic [7:0] fg, input logic [7:0] fb);
        logic [191:0] exp_nbr;
        exp_nbr = '0;
        applyStimulus(pix);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s rd_en k%0d", tag, k), 192'(bus_if.lut_rd_en), 192'(1'b1));
            checkOutput($sformatf("%s addr k%0d", tag, k), 192'(bus_if.lut_rd_addr), 192'(addrs[k]));
            exp_nbr[k*24 +: 24] = 24'(addrs[k]);
        end
        @(negedge clk);
        checkOutput({tag, " rd_en c9"}, 192'(bus_if.lut_rd_en), 192'(1'b0));
        checkOutput({tag, " interp c9"}, 192'(bus_if.interp_valid), 192'(1'b0));
        @(negedge clk);
        checkOutput({tag, " interp c10"}, 192'(bus_if.interp_valid), 192'(1'b0));
        @(negedge clk);
        checkOutput({tag, " interp c11"}, 192'(bus_if.interp_valid), 192'(1'b1));
        checkOutput({tag, " frac_r"}, 192'(bus_if.frac_r), 192'(fr));
        checkOutput({tag, " frac_g"}, 192'(bus_if.frac_g), 192'(fg));
        checkOutput({tag, " frac_b"}, 192'(bus_if.frac_b), 192'(fb));
        checkOutput({tag, " pt_nbr"}, bus_if.pt_nbr, exp_nbr);
        checkOutput({tag, " busy c11"}, 192'(bus_if.busy), 192'(1'b1));
        @(posedge clk);
        #1;
        checkOutput({tag, " interp c12"}, 192'(bus_if.interp_valid), 192'(1'b0));
        checkOutput({tag, " ready c12"}, 192'(bus_if.pix_ready), 192'(1'b1));
        checkOutput({tag, " pt_nbr hold"}, bus_if.pt_nbr, exp_nbr);
    endtask

    // Pixel expected to issue on time in cycle 11.
    task automatic runQuick(input string tag, input logic [23:0] pix);
        applyStimulus(pix);
        repeat (11) @(negedge clk);
        checkOutput({tag, " interp c11"}, 192'(bus_if.interp_valid), 192'(1'b1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn             = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = '0;
        bus_if.res_pop   = 1'b0;
        #2;
        checkOutput("reset pix_ready", 192'(bus_if.pix_ready), 192'(1'b1));
        checkOutput("reset busy", 192'(bus_if.busy), 192'(1'b0));
        checkOutput("reset rd_en", 192'(bus_if.lut_rd_en), 192'(1'b0));
        checkOutput("reset interp", 192'(bus_if.interp_valid), 192'(1'b0));
        checkOutput("reset addr", 192'(bus_if.lut_rd_addr), 192'(0));
        checkOutput("reset frac_r", 192'(bus_if.frac_r), 192'(0));
        checkOutput("reset pt_nbr", bus_if.pt_nbr, 192'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        runPixel("pixA", 24'h102035,
                 {13'd633, 13'd632, 13'd616, 13'd615, 13'd344, 13'd343, 13'd327, 13'd326},
                 8'h50, 8'h00, 8'h00);
        runPixel("pixTop", 24'hFFFFFF,
                 {13'd4912, 13'd4911, 13'd4895, 13'd4894, 13'd4623, 13'd4622, 13'd4606, 13'd4605},
                 8'hF0, 8'hF0, 8'hF0);

        // Reset during FETCH at corner 4.
        applyStimulus(24'h123456);
        repeat (5) @(negedge clk);
        checkOutput("midrst addr k4", 192'(bus_if.lut_rd_addr), 192'(634));
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midrst pix_ready", 192'(bus_if.pix_ready), 192'(1'b1));
        checkOutput("midrst busy", 192'(bus_if.busy), 192'(1'b0));
        checkOutput("midrst rd_en", 192'(bus_if.lut_rd_en), 192'(1'b0));
        checkOutput("midrst addr", 192'(bus_if.lut_rd_addr), 192'(0));
        checkOutput("midrst frac_r", 192'(bus_if.frac_r), 192'(0));
        checkOutput("midrst frac_g", 192'(bus_if.frac_g), 192'(0));
        checkOutput("midrst frac_b", 192'(bus_if.frac_b), 192'(0));
        checkOutput("midrst pt_nbr", bus_if.pt_nbr, 192'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        runPixel("pixPost", 24'h89ABCD,
                 {13'd2801, 13'd2800, 13'd2784, 13'd2783, 13'd2512, 13'd2511, 13'd2495, 13'd2494},
                 8'hD0, 8'hB0, 8'h90);

        // Seven more issues exhaust the eight credits.
        for (int i = 0; i < 7; i++) begin
            runQuick($sformatf("fill%0d", i), 24'(24'h010203 + i * 24'h131313));
        end

        // Ninth pixel starves in ISSUE for cycles 11..15.
        applyStimulus(24'h445566);
        repeat (10) @(negedge clk);
        for (int c = 11; c < 15; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall interp c%0d", c), 192'(bus_if.interp_valid), 192'(1'b0));
            checkOutput($sformatf("stall busy c%0d", c), 192'(bus_if.busy), 192'(1'b1));
            checkOutput($sformatf("stall ready c%0d", c), 192'(bus_if.pix_ready), 192'(1'b0));
        end
        @(posedge clk); #1;
        bus_if.res_pop = 1'b1;
        @(negedge clk);
        checkOutput("pop cycle interp", 192'(bus_if.interp_valid), 192'(1'b0));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("release interp", 192'(bus_if.interp_valid), 192'(1'b1));
        @(posedge clk); #1;
        bus_if.res_pop = 1'b0;
        checkOutput("release ready", 192'(bus_if.pix_ready), 192'(1'b1));
`ifdef LUT3D_CTRL_STATS_EN
        checkOutput("stat_pix_cnt", 192'(stat_pix), 192'(9));
        checkOutput("stat_stall_cnt", 192'(stat_stall), 192'(5));
`endif

        // Pop coincided with the release issue, so one credit remains.
        runQuick("credHold", 24'h0F1E2D);

        // Now empty again: stall until one pop.
        applyStimulus(24'h778899);
        repeat (11) @(negedge clk);
        checkOutput("empty interp c11", 192'(bus_if.interp_valid), 192'(1'b0));
        @(posedge clk); #1;
        bus_if.res_pop = 1'b1;
        @(negedge clk);
        checkOutput("empty interp c12", 192'(bus_if.interp_valid), 192'(1'b0));
        @(posedge clk); #1;
        bus_if.res_pop = 1'b0;
        @(negedge clk);
        checkOutput("empty interp c13", 192'(bus_if.interp_valid), 192'(1'b1));
        @(posedge clk); #1;
        checkOutput("final busy", 192'(bus_if.busy), 192'(1'b0));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
